// File: rtl/aes_frame_ctrl.sv
// aes_frame_ctrl
// Sequences one AES-over-UART frame: a 16-byte key followed by NUM_BLOCKS
// 16-byte plaintext blocks arrive as single bytes. Each block is handed to the
// AES core, and the ciphertext goes back out one byte at a time. A single
// pending-block buffer lets the next block arrive during encryption and
// transmission.
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   rx_valid, rx_data    received byte strobe and value
//   aes_key, aes_block   key / plaintext to the AES core (registered, held)
//   aes_start            one-cycle start pulse to the AES core
//   aes_done, aes_result AES completion strobe and ciphertext
//   tx_start, tx_data    one-cycle send request and byte to the transmitter
//   tx_busy              transmitter busy level
//   done                 frame complete level, cleared by the next received byte
//   overrun_err          pulse: a completed block was dropped (buffer full)
//   timeout_err          pulse: partial frame abandoned after an idle gap
module aes_frame_ctrl #(
    parameter int NUM_BLOCKS     = 4,
    parameter int TIMEOUT_CYCLES = 43400
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    output logic [127:0] aes_key,
    output logic [127:0] aes_block,
    output logic         aes_start,
    input  logic         aes_done,
    input  logic [127:0] aes_result,
    output logic         tx_start,
    output logic [7:0]   tx_data,
    input  logic         tx_busy,
    output logic         done,
    output logic         overrun_err,
    output logic         timeout_err
);
    localparam int BW = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BW-1:0] LAST_BLK  = BW'(NUM_BLOCKS - 1);
    localparam logic [TW-1:0] TOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {PH_KEY = 2'd0, PH_DATA = 2'd1, PH_FULL = 2'd2} phase_t;
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0, ST_START = 3'd1, ST_WAIT = 3'd2,
        ST_SEND = 3'd3, ST_HOLD = 3'd4, ST_FIN = 3'd5
    } state_t;

    phase_t          phase_r;
    logic [BW-1:0]   blk_cnt_r;
    logic [3:0]      byte_cnt_r;
    logic [119:0]    rx_shift_r;
    logic [127:0]    pend_buf_r;
    logic            pend_full_r;
    logic [TW-1:0]   tout_cnt_r;
    state_t          state_r, state_nxt_s;
    logic            hold_wait_r;
    logic [127:0]    tx_shift_r;
    logic [3:0]      tx_cnt_r;

    logic            rx_acc_s, grp_end_s, blk_end_s, accept_s;
    logic            tout_run_s, tout_fire_s;
    logic [127:0]    rx_word_s;
    logic            take_s, aes_start_nxt_s, tx_load_s, tx_fire_s, tx_adv_s, fin_s;

    // Receive-side decode: byte acceptance, group completion, timeout condition
    always_comb begin
        rx_acc_s    = rx_valid && (phase_r != PH_FULL);
        rx_word_s   = {rx_shift_r, rx_data};
        grp_end_s   = rx_acc_s && (byte_cnt_r == 4'd15);
        blk_end_s   = grp_end_s && (phase_r == PH_DATA);
        // the FSM emptying the buffer this same cycle makes room for the new block
        accept_s    = blk_end_s && (!pend_full_r || take_s);
        tout_run_s  = ((phase_r != PH_KEY) || (byte_cnt_r != 4'd0)) && (phase_r != PH_FULL);
        tout_fire_s = !rx_valid && tout_run_s && (tout_cnt_r == TOUT_LAST);
    end

    // Frame phase, byte assembly, key load and error pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_r     <= PH_KEY;
            blk_cnt_r   <= '0;
            byte_cnt_r  <= 4'd0;
            rx_shift_r  <= 120'd0;
            aes_key     <= 128'd0;
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
            if (tout_fire_s) begin
                timeout_err <= 1'b1;
                phase_r     <= PH_KEY;
                blk_cnt_r   <= '0;
                byte_cnt_r  <= 4'd0;
            end else if (fin_s) begin
                phase_r    <= PH_KEY;
                blk_cnt_r  <= '0;
                byte_cnt_r <= 4'd0;
            end else if (rx_acc_s) begin
                rx_shift_r <= rx_word_s[119:0];
                byte_cnt_r <= byte_cnt_r + 4'd1;
                if (grp_end_s && (phase_r == PH_KEY)) begin
                    aes_key   <= rx_word_s;
                    phase_r   <= PH_DATA;
                    blk_cnt_r <= '0;
                end else if (blk_end_s) begin
                    // a dropped block still advances the block count
                    overrun_err <= !accept_s;
                    if (blk_cnt_r == LAST_BLK) begin
                        phase_r <= PH_FULL;
                    end else begin
                        blk_cnt_r <= blk_cnt_r + BW'(1);
                    end
                end else begin
                    phase_r <= phase_r;
                end
            end else begin
                phase_r <= phase_r;
            end
        end
    end

    // Pending-block buffer between receiver and processing FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_buf_r  <= 128'd0;
            pend_full_r <= 1'b0;
        end else if (tout_fire_s) begin
            pend_full_r <= 1'b0;
        end else if (accept_s) begin
            pend_buf_r  <= rx_word_s;
            pend_full_r <= 1'b1;
        end else if (take_s) begin
            pend_full_r <= 1'b0;
        end else begin
            pend_full_r <= pend_full_r;
        end
    end

    // Inter-byte idle counter, only inside a partially received frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tout_cnt_r <= '0;
        end else if (rx_valid || tout_fire_s || !tout_run_s) begin
            tout_cnt_r <= '0;
        end else begin
            tout_cnt_r <= tout_cnt_r + TW'(1);
        end
    end

    // Frame-complete level: set on FIN, cleared by the next received byte
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done <= 1'b0;
        end else if (fin_s) begin
            done <= 1'b1;
        end else if (rx_valid) begin
            done <= 1'b0;
        end else begin
            done <= done;
        end
    end

    // Processing FSM next-state and control strobes
    always_comb begin
        state_nxt_s     = state_r;
        take_s          = 1'b0;
        aes_start_nxt_s = 1'b0;
        tx_load_s       = 1'b0;
        tx_fire_s       = 1'b0;
        tx_adv_s        = 1'b0;
        fin_s           = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pend_full_r) begin
                    take_s      = 1'b1;
                    state_nxt_s = ST_START;
                end else if (phase_r == PH_FULL) begin
                    state_nxt_s = ST_FIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                aes_start_nxt_s = 1'b1;
                state_nxt_s     = ST_WAIT;
            end
            ST_WAIT: begin
                if (aes_done) begin
                    tx_load_s   = 1'b1;
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_fire_s   = 1'b1;
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_HOLD: begin
                // first HOLD cycle: tx_busy has not risen yet, ignore it
                if (hold_wait_r) begin
                    state_nxt_s = ST_HOLD;
                end else if (!tx_busy) begin
                    if (tx_cnt_r == 4'd15) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        tx_adv_s    = 1'b1;
                        state_nxt_s = ST_SEND;
                    end
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            ST_FIN: begin
                fin_s       = 1'b1;
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Processing FSM state, AES handoff and transmit datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            aes_block   <= 128'd0;
            aes_start   <= 1'b0;
            tx_start    <= 1'b0;
            tx_data     <= 8'd0;
            tx_shift_r  <= 128'd0;
            tx_cnt_r    <= 4'd0;
            hold_wait_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            aes_start   <= aes_start_nxt_s;
            tx_start    <= tx_fire_s;
            hold_wait_r <= tx_fire_s;
            if (take_s) begin
                aes_block <= pend_buf_r;
            end else begin
                aes_block <= aes_block;
            end
            if (tx_load_s) begin
                tx_shift_r <= aes_result;
                tx_cnt_r   <= 4'd0;
            end else if (tx_fire_s) begin
                tx_data    <= tx_shift_r[127:120];
                tx_shift_r <= {tx_shift_r[119:0], 8'h00};
            end else if (tx_adv_s) begin
                tx_cnt_r <= tx_cnt_r + 4'd1;
            end else begin
                tx_cnt_r <= tx_cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_aes_frame_ctrl.sv
// Self-checking bench for aes_frame_ctrl: randomized byte pacing, random frame
// contents and random transmitter busy times, with a frame-level model that
// derives expected key, plaintext blocks and ciphertext bytes from the frame.
module tb_aes_frame_ctrl;
    localparam int NB   = 4;
    localparam int TOUT = 7000;

    logic         clk, reset, rx_valid, aes_start, aes_done, tx_start, tx_busy;
    logic         done, overrun_err, timeout_err;
    logic [7:0]   rx_data, tx_data;
    logic [127:0] aes_key, aes_block, aes_result;
    logic         uart_busy, stall_busy;

    assign tx_busy = uart_busy | stall_busy;

    aes_frame_ctrl #(.NUM_BLOCKS(NB), .TIMEOUT_CYCLES(TOUT)) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .aes_key(aes_key), .aes_block(aes_block), .aes_start(aes_start),
        .aes_done(aes_done), .aes_result(aes_result), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .done(done),
        .overrun_err(overrun_err), .timeout_err(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0, n_bad = 0;
    int n_start = 0, n_tx = 0, n_ovr = 0, n_tout = 0;
    logic [127:0] exp_key;
    logic [127:0] exp_blk_q[$];
    logic [7:0]   exp_tx_q[$];
    logic [7:0]   frm [80];
    bit hold_aes = 1'b0, aes_release = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endtask

    function automatic logic [127:0] pack(input int off);
        logic [127:0] w = 128'd0;
        for (int j = 0; j < 16; j++) w = {w[119:0], frm[off + j]};
        return w;
    endfunction

    // Model: key = bytes 0..15, block i = bytes 16+16i.., ciphertext = block ^ key sent MSB first
    task automatic expect_frame(input logic [3:0] mask);
        logic [127:0] k, b, c;
        k = pack(0);
        exp_key = k;
        for (int i = 0; i < NB; i++) begin
            if (mask[i]) begin
                b = pack(16 + 16 * i);
                exp_blk_q.push_back(b);
                c = b ^ k;
                for (int j = 0; j < 16; j++) exp_tx_q.push_back(c[127 - 8 * j -: 8]);
            end
        end
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 80; i++) frm[i] = 8'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat ($urandom_range(26, 38)) @(posedge clk);
    endtask

    task automatic send_range(input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(frm[i]);
    endtask

    task automatic wait_done(input string nm, input int bound);
        int k = 0;
        while (!done && k < bound) begin @(negedge clk); k++; end
        @(negedge clk);
        chk(nm, done, 1'b1);
    endtask

    task automatic clear_counts();
        n_start = 0; n_tx = 0; n_ovr = 0; n_tout = 0;
    endtask

    task automatic chk_outputs_zero(input string nm);
        chk({nm, " aes_key"}, aes_key, 128'd0);
        chk({nm, " aes_block"}, aes_block, 128'd0);
        chk({nm, " tx_data"}, tx_data, 8'd0);
        chk({nm, " pulses/done"}, {aes_start, tx_start, done, overrun_err, timeout_err}, 5'd0);
    endtask

    // Compare process: checks every AES start and every transmitted byte against the model
    always @(negedge clk) begin
        if (!reset) begin
            if (aes_start) begin
                n_start++;
                chk("aes_key at aes_start", aes_key, exp_key);
                if (exp_blk_q.size() > 0) chk("aes_block at aes_start", aes_block, exp_blk_q.pop_front());
                else begin n_cmp++; n_bad++; $display("FAIL aes_start: unexpected, block %h", aes_block); end
            end
            if (tx_start) begin
                n_tx++;
                chk("tx_busy low at tx_start", tx_busy, 1'b0);
                if (exp_tx_q.size() > 0) chk("tx_data", tx_data, exp_tx_q.pop_front());
                else begin n_cmp++; n_bad++; $display("FAIL tx_start: unexpected byte %h", tx_data); end
            end
            if (overrun_err) n_ovr++;
            if (timeout_err) n_tout++;
        end
    end

    // AES core model: result = block ^ key, done 10 cycles after start (or held on request)
    initial begin
        logic [127:0] b, k;
        aes_done = 1'b0; aes_result = 128'd0;
        forever begin
            @(negedge clk);
            if (aes_start && !reset) begin
                b = aes_block; k = aes_key;
                if (hold_aes) begin
                    hold_aes = 1'b0;
                    while (!aes_release) @(posedge clk);
                end else begin
                    repeat (9) @(posedge clk);
                end
                @(posedge clk); #1;
                aes_result = b ^ k; aes_done = 1'b1;
                @(posedge clk); #1;
                aes_done = 1'b0;
            end
        end
    end

    // Transmitter model: busy rises the cycle after tx_start for a random byte time
    initial begin
        uart_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && !reset) begin
                @(posedge clk); #1;
                uart_busy = 1'b1;
                repeat ($urandom_range(10, 18)) @(posedge clk);
                #1 uart_busy = 1'b0;
            end
        end
    end

    initial begin
        int k, t0;
        bit found;
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; stall_busy = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk_outputs_zero("reset");
        @(negedge clk) reset = 1'b0;

        // Nominal frame 0x00..0x4F
        clear_counts();
        for (int i = 0; i < 80; i++) frm[i] = 8'(i);
        expect_frame(4'b1111);
        chk("model block0", exp_blk_q[0], 128'h101112131415161718191a1b1c1d1e1f);
        chk("model first tx byte", exp_tx_q[0], 8'h10);
        send_range(0, 79);
        wait_done("nominal done", 3000);
        chk("nominal aes_key", aes_key, 128'h000102030405060708090a0b0c0d0e0f);
        chk("nominal tx count", n_tx, 64);
        chk("nominal overrun/timeout", {n_ovr, n_tout}, 64'd0);
        chk("nominal leftover", exp_tx_q.size(), 0);

        // Done clear by next byte, then a 5000-cycle busy stall
        clear_counts();
        rand_frame();
        frm[0] = 8'hAA;
        expect_frame(4'b1111);
        @(posedge clk); #1;
        rx_valid = 1'b1; rx_data = frm[0];
        @(negedge clk);
        chk("done held in clearing-byte cycle", done, 1'b1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("done cleared after byte", done, 1'b0);
        repeat (30) @(posedge clk);
        send_range(1, 15);
        chk("new key msb", aes_key[127:120], 8'hAA);
        send_range(16, 31);
        k = 0;
        while (!(n_tx >= 1 && uart_busy) && k < 2000) begin @(negedge clk); k++; end
        chk("transmitter busy before stall", uart_busy, 1'b1);
        stall_busy = 1'b1;
        t0 = n_tx;
        repeat (5000) @(negedge clk);
        chk("tx_start during stall", n_tx - t0, 0);
        stall_busy = 1'b0;
        send_range(32, 79);
        wait_done("stall done", 3000);
        chk("stall tx count", n_tx, 64);
        chk("stall overrun/timeout", {n_ovr, n_tout}, 64'd0);

        // Timeout: 20 bytes then silence
        clear_counts();
        rand_frame();
        send_range(0, 19);
        repeat (TOUT + 1) @(negedge clk);
        chk("timeout pulses", n_tout, 1);
        chk("no aes_start on aborted frame", n_start, 0);
        rand_frame();
        expect_frame(4'b1111);
        send_range(0, 79);
        wait_done("post-timeout done", 3000);
        chk("post-timeout key", aes_key, exp_key);
        chk("post-timeout tx count", n_tx, 64);
        chk("post-timeout pulses", {n_ovr, n_tout}, {32'd0, 32'd1});

        // Overrun: AES held while blocks 1 and 2 arrive; block 2 dropped
        clear_counts();
        rand_frame();
        expect_frame(4'b1011);
        hold_aes = 1'b1; aes_release = 1'b0;
        send_range(0, 63);
        repeat (50) @(negedge clk);
        chk("overrun pulse", n_ovr, 1);
        aes_release = 1'b1;
        k = 0;
        while (n_start < 2 && k < 2000) begin @(negedge clk); k++; end
        chk("block1 started after release", n_start, 2);
        send_range(64, 79);
        wait_done("overrun done", 3000);
        chk("overrun tx count", n_tx, 48);
        chk("overrun pulses", {n_ovr, n_tout}, {32'd1, 32'd0});
        chk("overrun leftover", exp_blk_q.size(), 0);

        // Reset in block 2 SEND, then a full frame
        clear_counts();
        rand_frame();
        expect_frame(4'b1111);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            send_byte(frm[i]);
            if (n_start >= 3 && n_tx >= 33) found = 1'b1;
        end
        chk("reached block2 send", found, 1'b1);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk_outputs_zero("mid reset");
        exp_blk_q.delete(); exp_tx_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (800) @(negedge clk);
        clear_counts();
        rand_frame();
        expect_frame(4'b1111);
        send_range(0, 79);
        wait_done("post-reset done", 3000);
        chk("post-reset key", aes_key, exp_key);
        chk("post-reset tx count", n_tx, 64);
        chk("post-reset pulses", {n_ovr, n_tout}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
